// File: rtl/ram_pkg.sv
// Shared SoC RAM map constants and the block mover state type.
package ram_pkg;

  localparam int unsigned CONST_BASE = 0;
  localparam int unsigned CONST_LAST = 1207;
  localparam int unsigned BLOCK_BASE = 1208;
  localparam int unsigned BLOCK_LAST = 1536;
  localparam int unsigned ROW_BASE   = 2000;
  localparam int unsigned ROW_LAST   = 3024;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } mover_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_addr_gen.sv
// Tile address generator: row/column counters, strided source pointer and packed
// destination pointer for the block mover.
module block_addr_gen #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BLK_ROWS = 8,
  parameter int unsigned BLK_COLS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] src_addr,
  input  logic [WIDTH-1:0] dst_addr,
  input  logic [WIDTH-1:0] stride,
  output logic [WIDTH-1:0] src_ptr,
  output logic [WIDTH-1:0] dst_ptr,
  output logic             last
);
  import ram_pkg::*;

  localparam int unsigned RW = cnt_w(BLK_ROWS);
  localparam int unsigned CW = cnt_w(BLK_COLS);
  localparam logic [RW-1:0] RLast = RW'(BLK_ROWS - 1);
  localparam logic [CW-1:0] CLast = CW'(BLK_COLS - 1);

  logic [RW-1:0]    r_q, r_d;
  logic [CW-1:0]    c_q, c_d;
  logic [WIDTH-1:0] row_base_q, row_base_d;
  logic [WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [WIDTH-1:0] stride_q, stride_d;
  logic             col_last;

  assign col_last = (c_q == CLast);
  assign last     = col_last && (r_q == RLast);
  assign src_ptr  = src_ptr_q;
  assign dst_ptr  = dst_ptr_q;

  // src_ptr_q tracks row_base_q + c_q incrementally; adds wrap modulo 2^WIDTH.
  always_comb begin
    r_d        = r_q;
    c_d        = c_q;
    row_base_d = row_base_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    stride_d   = stride_q;
    if (load) begin
      r_d        = '0;
      c_d        = '0;
      row_base_d = src_addr;
      src_ptr_d  = src_addr;
      dst_ptr_d  = dst_addr;
      stride_d   = stride;
    end else if (advance) begin
      dst_ptr_d = dst_ptr_q + WIDTH'(1);
      if (col_last) begin
        c_d        = '0;
        r_d        = r_q + RW'(1);
        row_base_d = row_base_q + stride_q;
        src_ptr_d  = row_base_q + stride_q;
      end else begin
        c_d       = c_q + CW'(1);
        src_ptr_d = src_ptr_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      c_q        <= '0;
      row_base_q <= '0;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      stride_q   <= '0;
    end else begin
      r_q        <= r_d;
      c_q        <= c_d;
      row_base_q <= row_base_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      stride_q   <= stride_d;
    end
  end

endmodule

// File: rtl/ram_block_mover.sv
// Bus initiator copying a BLK_ROWS x BLK_COLS word tile between RAM regions,
// one read cycle and one write cycle per word, only while the arbiter grants.
module ram_block_mover #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BLK_ROWS = 8,
  parameter int unsigned BLK_COLS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src_addr,
  input  logic [WIDTH-1:0] dst_addr,
  input  logic [WIDTH-1:0] stride,
  output logic             busy,
  output logic             done,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] wdata,
  output logic             enw,
  input  logic [WIDTH-1:0] rdata
);
  import ram_pkg::*;

  mover_state_t     state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] src_ptr;
  logic [WIDTH-1:0] dst_ptr;
  logic             last;
  logic             load;
  logic             advance;

  assign load    = (state_q == IDLE) && start;
  assign advance = (state_q == WRITE) && mem_gnt;

  block_addr_gen #(
    .WIDTH   (WIDTH),
    .BLK_ROWS(BLK_ROWS),
    .BLK_COLS(BLK_COLS)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .stride  (stride),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr),
    .last    (last)
  );

  // Without a grant the mover stalls in place; pointers and data_q are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_q <= READ;
        end
        READ: begin
          if (mem_gnt) begin
            data_q  <= rdata;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (mem_gnt) state_q <= last ? DONE : READ;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    mem_req = (state_q == READ) || (state_q == WRITE);
    enw     = (state_q == WRITE) && mem_gnt;
    address = '0;
    wdata   = '0;
    if (mem_gnt) begin
      if (state_q == READ) begin
        address = src_ptr;
      end else if (state_q == WRITE) begin
        address = dst_ptr;
        wdata   = data_q;
      end
    end
  end

endmodule
